// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle for the bit-serial adder.
// Optional SERIAL_ADDER_SUB_EN adds the 'sub' request bit.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus carry FF, operands fed LSB-first.
// Define SERIAL_ADDER_SUB_EN to add a subtract request (a - b via ~b and carry-in 1).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] sh_a_reg;
  logic [WIDTH-1:0] sh_b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [CW-1:0]    count_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             sub_sel;
  logic             fa_s;
  logic             fa_c;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_sel = bus.sub;
`else
  assign sub_sel = 1'b0;
`endif

  // The single full-adder cell; carry-out is the majority of its three inputs.
  assign fa_s = sh_a_reg[0] ^ sh_b_reg[0] ^ carry_reg;
  assign fa_c = (sh_a_reg[0] & sh_b_reg[0]) | (sh_b_reg[0] & carry_reg) | (carry_reg & sh_a_reg[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      sh_a_reg  <= '0;
      sh_b_reg  <= '0;
      sum_reg   <= '0;
      count_reg <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            sh_a_reg  <= bus.a;
            sh_b_reg  <= sub_sel ? ~bus.b : bus.b;
            carry_reg <= sub_sel ? 1'b1 : bus.cin;
            count_reg <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
          sum_reg   <= {fa_s, sum_reg[WIDTH-1:1]};
          sh_a_reg  <= {1'b0, sh_a_reg[WIDTH-1:1]};
          sh_b_reg  <= {1'b0, sh_b_reg[WIDTH-1:1]};
          carry_reg <= fa_c;
          if (count_reg == LAST_BIT) begin
            state_reg <= ST_DONE;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
        ST_DONE: begin
          cout_reg  <= carry_reg;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: driver pushes expected results, monitor pops on done.
// Build with SERIAL_ADDER_SUB_EN defined to also exercise subtraction.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           cyc;
    string        name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   neg_cnt;
  exp_t sb[$];

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: one line per completed transaction.
  always @(negedge clk) begin
    exp_t e;
    neg_cnt = neg_cnt + 1;
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 expected no pending op (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        $display("txn %s: sum=%0h cout=%0b cyc=%0d", e.name, bus.sum, bus.cout, neg_cnt);
        chk({e.name, "_sum"}, 32'(bus.sum), 32'(e.sum));
        chk({e.name, "_cout"}, 32'(bus.cout), 32'(e.cout));
        chk({e.name, "_latency"}, 32'(neg_cnt), 32'(e.cyc));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (bus.busy === 1'b1 && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) chk("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  // Drives an accepted start (caller guarantees IDLE), pushes the reference result.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic sub, input string nm);
    exp_t e;
    int   total;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = ci;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = sub;
    if (sub) begin
      e.sum  = W'(int'(a) - int'(b));
      e.cout = (a >= b);
    end else begin
      total  = int'(a) + int'(b) + int'(ci);
      e.sum  = W'(total);
      e.cout = (total >= (1 << W));
    end
`else
    total  = int'(a) + int'(b) + int'(ci) + 0 * int'(sub);
    e.sum  = W'(total);
    e.cout = (total >= (1 << W));
`endif
    e.cyc  = neg_cnt + W + 2;
    e.name = nm;
    sb.push_back(e);
    step();
    bus.start = 1'b0;
    // Operand changes after capture must not matter.
    bus.a   = W'($urandom);
    bus.b   = W'($urandom);
    bus.cin = 1'($urandom);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    neg_cnt   = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = 1'b0;
`endif
    step();
    step();
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_sum",  32'(bus.sum),  32'd0);
    chk("reset_cout", 32'(bus.cout), 32'd0);
    rst_n = 1'b1;
    step();

    // Directed basics and carry boundaries.
    issue(8'h3C, 8'h05, 1'b0, 1'b0, "add_3c_05");
    chk("busy_in_run", 32'(bus.busy), 32'd1);
    wait_idle();
    issue(8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
    wait_idle();
    issue(8'hFF, 8'hFF, 1'b1, 1'b0, "add_ff_ff_c");
    wait_idle();

    // Start during RUN is ignored.
    issue(8'h10, 8'h20, 1'b0, 1'b0, "add_10_20");
    step();
    step();
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    step();
    bus.start = 1'b0;
    wait_idle();
    step();

    // Asynchronous reset mid-operation.
    issue(8'hAA, 8'h55, 1'b1, 1'b0, "aborted");
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_done", 32'(bus.done), 32'd0);
    chk("async_rst_sum",  32'(bus.sum),  32'd0);
    chk("async_rst_cout", 32'(bus.cout), 32'd0);
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
    issue(8'h7F, 8'h01, 1'b0, 1'b0, "add_7f_01");
    wait_idle();
    step();

    // Start in DONE ignored; start in the following IDLE cycle accepted.
    issue(8'h12, 8'h34, 1'b0, 1'b0, "add_12_34");
    for (int i = 0; i < W; i++) step();
    chk("done_state_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b1;
    bus.a     = 8'h01;
    bus.b     = 8'h01;
    step();
    bus.start = 1'b0;
    chk("sum_held_before_restart", 32'(bus.sum), 32'h46);
    chk("idle_after_done_busy", 32'(bus.busy), 32'd0);
    issue(8'h80, 8'h80, 1'b1, 1'b0, "b2b_80_80");
    wait_idle();

`ifdef SERIAL_ADDER_SUB_EN
    step();
    issue(8'h05, 8'h07, 1'b0, 1'b1, "sub_05_07");
    wait_idle();
    issue(8'h07, 8'h05, 1'b1, 1'b1, "sub_07_05");
    wait_idle();
`endif

    // Randomized operations with random idle gaps.
    for (int i = 0; i < 24; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) step();
      wait_idle();
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
    end

    begin
      int guard = 0;
      while (sb.size() != 0 && guard < 60) begin
        step();
        guard++;
      end
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    end
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
